// File: rtl/spi_slave_pkg.sv
// Shared types and widths for the SPI slave register bank.
package spi_slave_pkg;

  localparam int unsigned CMD_RD_BIT = 7;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StDone
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses; ResetVal sets the idle level.
module spi_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
    prev_d = sync_q[1];
    rise_d = sync_q[1] & ~prev_q;
    fall_d = ~sync_q[1] & prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{ResetVal}};
      prev_q <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_o    = sync_q[1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave register bank, oversampled in the ACLK domain.
// Optional address auto-increment bursts: define SPI_SLAVE_AUTOINC_EN.
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int unsigned       NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       SPI_SCK,
  input  logic                       SPI_CSn,
  input  logic                       SPI_MOSI,
  output logic                       SPI_MISO,
  output logic                       SPI_MISO_OE,
  output logic [DATA_W*NUM_REGS-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data
);

`ifdef SPI_SLAVE_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic sck_s, sck_rise, sck_fall;
  logic csn_s, csn_rise, csn_fall;
  logic [1:0] mosi_sync_q;
  logic       mosi_s;

  spi_sync_edge #(.ResetVal(1'b0)) u_sck_sync (
    .clk_i  (ACLK),
    .rst_ni (ARESETn),
    .d_i    (SPI_SCK),
    .q_o    (sck_s),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.ResetVal(1'b1)) u_csn_sync (
    .clk_i  (ACLK),
    .rst_ni (ARESETn),
    .d_i    (SPI_CSn),
    .q_o    (csn_s),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) mosi_sync_q <= 2'b00;
    else          mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
  end
  assign mosi_s = mosi_sync_q[1];

  spi_state_e state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // A pulse whose synchronised level has already reverted is treated as a glitch.
  logic              rise_ok, fall_ok, byte_end, cmd_end, data_end;
  logic [DATA_W-1:0] rx_byte;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (csn_rise) begin
      state_d = StIdle;
    end else if (csn_fall) begin
      state_d = StCmd;
    end else if (byte_end) begin
      case (state_q)
        StCmd:   state_d = StData;
        StData:  state_d = AutoInc ? StData : StDone;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rise_ok  = sck_rise & sck_s & (state_q != StIdle);
    fall_ok  = sck_fall & ~sck_s & (state_q != StIdle);
    rx_byte  = {shift_q[DATA_W-2:0], mosi_s};
    byte_end = rise_ok && (bit_cnt_q == 3'd7);
    cmd_end  = byte_end && (state_q == StCmd);
    data_end = byte_end && (state_q == StData);
  end

  logic [ADDR_W-1:0] tx_addr;
  logic [DATA_W-1:0] tx_val;
  logic              addr_hit;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    tx_addr  = cmd_end ? rx_byte[ADDR_W-1:0] : addr_q + 7'd1;
    tx_val   = '0;
    addr_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (tx_addr == ADDR_W'(i)) tx_val = regs_q[i];
      if (addr_q == ADDR_W'(i))  addr_hit = 1'b1;
    end

    if (csn_fall || csn_rise) begin
      bit_cnt_d = '0;
      tx_d      = '0;
    end else begin
      if (rise_ok) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = rx_byte;
      end
      // The fall right after a byte boundary keeps bit 7 on MISO for the next rise.
      if (fall_ok && bit_cnt_q != 3'd0) tx_d = {tx_q[DATA_W-2:0], 1'b0};
      if (cmd_end) begin
        rd_d   = rx_byte[CMD_RD_BIT];
        addr_d = rx_byte[ADDR_W-1:0];
        tx_d   = rx_byte[CMD_RD_BIT] ? tx_val : '0;
      end
      if (data_end) begin
        if (!rd_q && addr_hit) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) regs_d[i] = rx_byte;
          end
          wr_strobe_d = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = rx_byte;
        end
        if (AutoInc) begin
          addr_d = addr_q + 7'd1;
          tx_d   = rd_q ? tx_val : '0;
        end else begin
          tx_d = '0;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[DATA_W*g +: DATA_W] = regs_q[g];
  end

  assign SPI_MISO    = tx_q[DATA_W-1];
  assign SPI_MISO_OE = ~csn_s;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed plus randomised SPI frames checked against a byte-level register model.
module tb_spi_slave_regs;

  localparam int unsigned NumRegs = 16;
  localparam int unsigned Half    = 6;

  logic                   aclk = 1'b0;
  logic                   aresetn, sck, csn, mosi;
  logic                   miso, miso_oe, wr_strobe;
  logic [8*NumRegs-1:0]   regs_flat;
  logic [6:0]             wr_addr;
  logic [7:0]             wr_data;

  always #5 aclk = ~aclk;

  spi_slave_regs #(.NUM_REGS(NumRegs), .RESET_VAL(8'h00)) u_dut (
    .ACLK        (aclk),
    .ARESETn     (aresetn),
    .SPI_SCK     (sck),
    .SPI_CSn     (csn),
    .SPI_MOSI    (mosi),
    .SPI_MISO    (miso),
    .SPI_MISO_OE (miso_oe),
    .regs_flat   (regs_flat),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  int n_pass, n_total;
  logic [7:0] mem [NumRegs];
  int         exp_strobes;
  logic [6:0] exp_waddr;
  logic [7:0] exp_wdata;
  logic [7:0] tx_bytes[$];
  logic [7:0] rx_bytes[$];

  int   strobe_cnt  = 0;
  int   strobe_wide = 0;
  logic strobe_prev = 1'b0;

  always @(negedge aclk) begin
    if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    if (wr_strobe && strobe_prev) strobe_wide <= strobe_wide + 1;
    strobe_prev <= wr_strobe;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*NumRegs-1:0] mem_flat();
    logic [8*NumRegs-1:0] f;
    for (int i = 0; i < NumRegs; i++) f[8*i +: 8] = mem[i];
    return f;
  endfunction

  // Bit-bangs tx_bytes for nbits clocks; MISO is sampled just before each rising edge.
  task automatic run_frame(input int nbits);
    logic [7:0] cur, t;
    cur = '0;
    rx_bytes.delete();
    @(posedge aclk); #2 csn = 1'b0;
    repeat (Half) @(posedge aclk);
    #2;
    for (int i = 0; i < nbits; i++) begin
      t    = tx_bytes[i/8];
      mosi = t[7-(i%8)];
      repeat (Half) @(posedge aclk);
      #2;
      cur = {cur[6:0], miso};
      sck = 1'b1;
      repeat (Half) @(posedge aclk);
      #2 sck = 1'b0;
      if (i % 8 == 7) rx_bytes.push_back(cur);
    end
    repeat (Half) @(posedge aclk);
    #2 csn = 1'b1;
    mosi = 1'b0;
    repeat (10) @(posedge aclk);
    #2;
  endtask

  task automatic do_frame(input int nbits, input string tag);
    logic [7:0] cmd, exp_miso [$];
    logic [6:0] a;
    int         nfull;
    bit         active;
    run_frame(nbits);
    cmd   = tx_bytes[0];
    nfull = nbits / 8;
    exp_miso.delete();
    if (nfull >= 1) exp_miso.push_back(8'h00);
    for (int k = 1; k < nfull; k++) begin
      a = cmd[6:0] + 7'(k - 1);
`ifdef SPI_SLAVE_AUTOINC_EN
      active = 1'b1;
`else
      active = (k == 1);
`endif
      if (!active) begin
        exp_miso.push_back(8'h00);
      end else if (cmd[7]) begin
        exp_miso.push_back(int'(a) < NumRegs ? mem[a[3:0]] : 8'h00);
      end else begin
        exp_miso.push_back(8'h00);
        if (int'(a) < NumRegs) begin
          mem[a[3:0]] = tx_bytes[k];
          exp_strobes++;
          exp_waddr = a;
          exp_wdata = tx_bytes[k];
        end
      end
    end
    for (int k = 0; k < nfull; k++) check({tag, "_miso"}, rx_bytes[k], exp_miso[k]);
    check({tag, "_regs"}, regs_flat, mem_flat());
    check({tag, "_nstrobe"}, strobe_cnt, exp_strobes);
    check({tag, "_waddr"}, wr_addr, exp_waddr);
    check({tag, "_wdata"}, wr_data, exp_wdata);
  endtask

  task automatic reset_model();
    for (int i = 0; i < NumRegs; i++) mem[i] = 8'h00;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  initial begin
    int nbytes, nbits;
    aresetn = 1'b0; csn = 1'b1; sck = 1'b0; mosi = 1'b0;
    n_pass = 0; n_total = 0; exp_strobes = 0;
    reset_model();
    repeat (3) @(posedge aclk);
    #2;
    check("rst_miso", miso, 1'b0);
    check("rst_oe", miso_oe, 1'b0);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_regs", regs_flat, '0);
    check("rst_waddr", wr_addr, 7'h00);
    check("rst_wdata", wr_data, 8'h00);
    aresetn = 1'b1;
    repeat (4) @(posedge aclk);

    tx_bytes = '{8'h05, 8'hA5};               do_frame(16, "wr05");
    tx_bytes = '{8'h85, 8'h00};               do_frame(16, "rd05");
    tx_bytes = '{8'h20, 8'hFF};               do_frame(16, "wr20");
    tx_bytes = '{8'hA0, 8'h00};               do_frame(16, "rd20");
    tx_bytes = '{8'h03, 8'h5C};               do_frame(13, "abort03");
    tx_bytes = '{8'h83, 8'h00};               do_frame(16, "rd03");
    tx_bytes = '{8'h0E, 8'h11, 8'h22, 8'h33}; do_frame(32, "burst0e");
    tx_bytes = '{8'h8E, 8'h00, 8'h00};        do_frame(24, "rdburst");
    tx_bytes = '{8'h02, 8'h7E};               do_frame(16, "wr02");

    // Reset asserted in the middle of a frame.
    @(posedge aclk); #2 csn = 1'b0;
    repeat (Half) @(posedge aclk);
    for (int i = 0; i < 3; i++) begin
      #2 sck = 1'b1;
      repeat (Half) @(posedge aclk);
      #2 sck = 1'b0;
      repeat (Half) @(posedge aclk);
    end
    #2 aresetn = 1'b0;
    reset_model();
    repeat (3) @(posedge aclk);
    #2;
    check("midrst_regs", regs_flat, mem_flat());
    check("midrst_miso", miso, 1'b0);
    check("midrst_oe", miso_oe, 1'b0);
    check("midrst_strobe", wr_strobe, 1'b0);
    csn = 1'b1;
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    repeat (4) @(posedge aclk);
    tx_bytes = '{8'h09, 8'hC3};               do_frame(16, "postrst_wr");
    tx_bytes = '{8'h89, 8'h00};               do_frame(16, "postrst_rd");

    for (int f = 0; f < 20; f++) begin
      tx_bytes.delete();
      nbytes = $urandom_range(2, 4);
      tx_bytes.push_back({1'($urandom_range(0, 1)), 7'($urandom_range(0, 20))});
      for (int k = 1; k < nbytes; k++) tx_bytes.push_back(8'($urandom));
      nbits = 8 * nbytes;
      if ($urandom_range(0, 5) == 0) nbits = nbits - $urandom_range(1, 7);
      do_frame(nbits, "rand");
    end

    check("strobe_width", strobe_wide, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI slave register bank that sits directly downstream of the AXI-Lite SPI master peripheral and terminates its SPI_SCK/SPI_MOSI/SPI_CSn lines. It provides a byte-addressed register file to local logic, so the whole AXI→SPI→register path can be built and verified on one chip. All SPI inputs are oversampled in the ACLK domain; there is no second clock.

## Interface
- NUM_REGS, 16: number of implemented 8-bit registers (1..128), at addresses 0..NUM_REGS-1.
- RESET_VAL, 8'h00: reset value of every register.
- ACLK  in  1  system clock; must be ≥ 8× SPI_SCK frequency.
- ARESETn  in  1  asynchronous, active-low reset.
- SPI_SCK  in  1  serial clock from master, mode 0 (CPOL=0, CPHA=0).
- SPI_CSn  in  1  chip select, active low.
- SPI_MOSI  in  1  serial data in, MSB first.
- SPI_MISO  out  1  serial data out, MSB first; reset 0.
- SPI_MISO_OE  out  1  high while the synchronised CSn is low; reset 0.
- regs_flat  out  8*NUM_REGS  register contents, reg[i] at bits [8i+7:8i]; reset all RESET_VAL.
- wr_strobe  out  1  one-ACLK pulse per completed register write; reset 0.
- wr_addr  out  7  address of the last write; reset 0.
- wr_data  out  8  data of the last write; reset 0.

## Operation
- SCK, CSn, MOSI each pass through a 2-FF synchroniser; SCK rise/fall and CSn fall/rise are detected from the synchronised values.
- Frame: CSn falling → byte 0 = command {R/nW (bit 7, 1=read), addr[6:0]}, then data byte(s). MOSI sampled on SCK rising; MISO updated on SCK falling.
- FSM: IDLE → CMD on CSn fall; CMD → DATA after 8th rising edge; DATA → DATA (next byte) or DONE after each 8th rising edge; any state → IDLE on CSn rise.
- 3-bit bit counter, cleared on CSn fall and on every byte boundary.
- Write: on 8th rising edge of a data byte, if addr < NUM_REGS: reg[addr] ← byte, wr_strobe pulses, wr_addr/wr_data update. addr ≥ NUM_REGS: no write, no strobe.
- Read: on the command byte's 8th rising edge, load tx shift register with reg[addr] (8'h00 if addr ≥ NUM_REGS); bit 7 drives MISO from that point, subsequent bits shift out on each SCK falling edge.
- MISO is 0 during the command byte, in DONE, and in write frames.
- CSn rising mid-byte: partial byte discarded, no write, FSM → IDLE, MISO → 0.
- SCK edges while CSn high are ignored.
- ARESETn low at any time: FSM → IDLE, counters cleared, registers → RESET_VAL, all outputs to reset values.

## Timing
- Edge detection latency: 3 ACLK after the pin edge (2 sync + 1 detect).
- wr_strobe asserts 1 ACLK after the detected 8th data rising edge, for exactly 1 ACLK; regs_flat updates in the same cycle.
- MISO settles ≤ 4 ACLK after an SCK falling edge; SCK half-period must therefore be ≥ 4 ACLK (SCK ≤ ACLK/8).
- A read frame returns the register value captured at the command byte boundary; a write strobe in the same ACLK is not reflected.

## Configuration
- SPI_SLAVE_AUTOINC_EN defined: after each data byte, addr ← addr+1 (modulo 128) and the frame continues in DATA; reads reload tx from the new address, writes target it. Bursts are unbounded until CSn rises.
- Undefined: after the first data byte the FSM enters DONE; further bytes are ignored (no writes, MISO 0).

## Structure
- Package spi_slave_pkg: FSM state enum (IDLE, CMD, DATA, DONE), CMD_RD_BIT = 7, ADDR_W = 7, DATA_W = 8.
- Sub-module spi_sync_edge: 2-FF synchroniser plus rise/fall pulse outputs, instantiated for SCK and CSn; MOSI uses the synchroniser only.

## Test plan
- Write 0x05 ← 0xA5 (frame 0x05,0xA5) → one wr_strobe, wr_addr=0x05, wr_data=0xA5, regs_flat[47:40]=0xA5.
- Then read 0x05 (frame 0x85,0x00) → MISO bytes 0x00,0xA5; no wr_strobe.
- Write 0x20 ← 0xFF with NUM_REGS=16 → no strobe, regs unchanged; read 0x20 → 0x00.
- CSn raised after 5 bits of a data byte to 0x03 → reg[3] stays RESET_VAL, next frame decodes normally.
- With SPI_SLAVE_AUTOINC_EN: frame 0x0E,0x11,0x22,0x33 → reg[14]=0x11, reg[15]=0x22, addr 0x10 ignored, 2 strobes; without macro: only reg[14]=0x11.
- ARESETn pulsed mid-frame after a write to reg[2]=0x7E → all regs RESET_VAL, MISO/OE/wr_strobe 0, next frame works.
